// File: rtl/counter_cmd_controller.sv
// counter_cmd_controller: turns debounced up/down/clear button levels into
// single-cycle commands for the LED counter, with fixed-priority arbitration,
// hold-to-auto-repeat and saturation at the counter limits.
module counter_cmd_controller #(
   parameter int WIDTH         = 8,
   parameter int MAX_VALUE     = 255,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_clr,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_dir,
   output logic             cnt_clr,
   output logic             busy,
   output logic [1:0]       active_src
);

   // The timer is shared by the hold and repeat phases, so it is sized for the longer one
   localparam int TIMER_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW         = $clog2(TIMER_SPAN);

   localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]    REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
   localparam logic [TW-1:0]    TIMER_TOP   = '1;
   localparam logic [WIDTH-1:0] MAX_LIMIT   = WIDTH'(MAX_VALUE);

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_UP   = 2'b01;
   localparam logic [1:0] SRC_DOWN = 2'b10;
   localparam logic [1:0] SRC_CLR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_REPEAT,
      S_RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       btn_q, btn_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             cnt_en_q, cnt_en_d;
   logic             cnt_dir_q, cnt_dir_d;
   logic             cnt_clr_q, cnt_clr_d;
   logic             busy_q, busy_d;
   logic [1:0]       active_src_q, active_src_d;

   logic             up_rise;
   logic             down_rise;
   logic             clr_rise;
   logic             owner_held;
   logic             step_req;
   logic             step_up;

   // Next-state and next-output decode; a requested step is filtered by saturation afterwards
   always_comb begin
      btn_d        = {btn_clr, btn_down, btn_up};
      up_rise      = btn_up   & ~btn_q[0];
      down_rise    = btn_down & ~btn_q[1];
      clr_rise     = btn_clr  & ~btn_q[2];
      owner_held   = (active_src_q == SRC_UP) ? btn_up : btn_down;

      state_d      = state_q;
      timer_d      = (timer_q == TIMER_TOP) ? timer_q : timer_q + 1'b1;
      cnt_en_d     = 1'b0;
      cnt_dir_d    = 1'b0;
      cnt_clr_d    = 1'b0;
      active_src_d = active_src_q;
      step_req     = 1'b0;
      step_up      = 1'b0;

      case (state_q)
         S_IDLE: begin
            active_src_d = SRC_NONE;
            if (clr_rise) begin
               cnt_clr_d    = 1'b1;
               active_src_d = SRC_CLR;
               state_d      = S_RELEASE;
            end else if (up_rise) begin
               active_src_d = SRC_UP;
               step_req     = 1'b1;
               step_up      = 1'b1;
               state_d      = S_ARMED;
            end else if (down_rise) begin
               active_src_d = SRC_DOWN;
               step_req     = 1'b1;
               state_d      = S_ARMED;
            end
         end

         S_ARMED, S_REPEAT: begin
            if (clr_rise) begin
               cnt_clr_d    = 1'b1;
               active_src_d = SRC_CLR;
               state_d      = S_RELEASE;
            end else if (!owner_held) begin
               active_src_d = SRC_NONE;
               state_d      = S_IDLE;
            end else if (state_q == S_ARMED && timer_q == HOLD_LAST) begin
               step_req = 1'b1;
               step_up  = (active_src_q == SRC_UP);
               state_d  = S_REPEAT;
            end else if (state_q == S_REPEAT && timer_q == REPEAT_LAST) begin
               step_req = 1'b1;
               step_up  = (active_src_q == SRC_UP);
               timer_d  = '0;
            end
         end

         S_RELEASE: begin
            if (!btn_up && !btn_down && !btn_clr) begin
               active_src_d = SRC_NONE;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_RELEASE;
         end
      endcase

      if (step_req) begin
         if (step_up) begin
            if (cnt_value < MAX_LIMIT) begin
               cnt_en_d  = 1'b1;
               cnt_dir_d = 1'b1;
            end
         end else if (cnt_value != '0) begin
            cnt_en_d = 1'b1;
         end
      end

      if (state_d != state_q) begin
         timer_d = '0;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, button history, timer and all outputs are registered; reset parks in RELEASE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RELEASE;
         btn_q        <= 3'b000;
         timer_q      <= '0;
         cnt_en_q     <= 1'b0;
         cnt_dir_q    <= 1'b0;
         cnt_clr_q    <= 1'b0;
         busy_q       <= 1'b1;
         active_src_q <= SRC_NONE;
      end else begin
         state_q      <= state_d;
         btn_q        <= btn_d;
         timer_q      <= timer_d;
         cnt_en_q     <= cnt_en_d;
         cnt_dir_q    <= cnt_dir_d;
         cnt_clr_q    <= cnt_clr_d;
         busy_q       <= busy_d;
         active_src_q <= active_src_d;
      end
   end

   assign cnt_en     = cnt_en_q;
   assign cnt_dir    = cnt_dir_q;
   assign cnt_clr    = cnt_clr_q;
   assign busy       = busy_q;
   assign active_src = active_src_q;

endmodule

// File: tb/tb_counter_cmd_controller.sv
// tb_counter_cmd_controller: directed bench for the button command sequencer,
// run with short hold/repeat times so auto-repeat timing is easy to hand-check.
module tb_counter_cmd_controller;

   logic       clk;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       btn_clr;
   logic [7:0] cnt_value;
   logic       cnt_en;
   logic       cnt_dir;
   logic       cnt_clr;
   logic       busy;
   logic [1:0] active_src;

   int          checks;
   int          errors;
   int          cyc;
   int          base;
   int          en_count;
   int          down_count;
   int          clr_count;
   logic [31:0] en_mask;

   counter_cmd_controller #(
      .WIDTH(8),
      .MAX_VALUE(255),
      .HOLD_CYCLES(8),
      .REPEAT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_clr(btn_clr),
      .cnt_value(cnt_value),
      .cnt_en(cnt_en),
      .cnt_dir(cnt_dir),
      .cnt_clr(cnt_clr),
      .busy(busy),
      .active_src(active_src)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter so pulse positions can be recorded relative to a press
   always @(posedge clk) begin
      cyc = cyc + 1;
   end

   // Pulse monitor on the falling edge: counts steps/clears, records step positions
   // and checks that a step and a clear never coincide
   always @(negedge clk) begin
      int off;
      if (!rst) begin
         checks = checks + 1;
         assert (!(cnt_en && cnt_clr)) else begin
            errors = errors + 1;
            $error("[TB] FAIL en_clr_exclusive: observed en=%0b clr=%0b expected not both", cnt_en, cnt_clr);
         end
         if (cnt_en) begin
            en_count = en_count + 1;
            if (!cnt_dir) down_count = down_count + 1;
            off = cyc - base;
            if (off >= 0 && off < 32) en_mask[off] = 1'b1;
         end
         if (cnt_clr) clr_count = clr_count + 1;
      end
   end

   // Drive all button levels and the counter value at once
   task automatic applyStimulus(input logic up, input logic down, input logic clr, input logic [7:0] value);
      btn_up    = up;
      btn_down  = down;
      btn_clr   = clr;
      cnt_value = value;
   endtask

   // Advance n clock edges, landing 1 ns after the last rising edge
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Restart pulse bookkeeping; positions are measured from the current cycle
   task automatic clearCounters();
      en_count   = 0;
      down_count = 0;
      clr_count  = 0;
      en_mask    = '0;
      base       = cyc;
   endtask

   // One immediate-assertion comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         errors = errors + 1;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Directed sequence of scenarios with hand-computed expectations
   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      base   = 0;
      en_count = 0;
      down_count = 0;
      clr_count = 0;
      en_mask = '0;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);

      // Scenario 1: reset values, then a short up press gives exactly one step
      $display("[TB] scenario 1: reset and single up press");
      cycles(3);
      checkOutput("rst_en", {31'd0, cnt_en}, 32'd0);
      checkOutput("rst_dir", {31'd0, cnt_dir}, 32'd0);
      checkOutput("rst_clr", {31'd0, cnt_clr}, 32'd0);
      checkOutput("rst_src", {30'd0, active_src}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      cycles(1);
      checkOutput("s1_idle_busy", {31'd0, busy}, 32'd0);
      clearCounters();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
      cycles(1);
      checkOutput("s1_en", {31'd0, cnt_en}, 32'd1);
      checkOutput("s1_dir", {31'd0, cnt_dir}, 32'd1);
      checkOutput("s1_src", {30'd0, active_src}, 32'd1);
      checkOutput("s1_busy", {31'd0, busy}, 32'd1);
      cycles(2);
      checkOutput("s1_en_low", {31'd0, cnt_en}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
      cycles(1);
      checkOutput("s1_rel_busy", {31'd0, busy}, 32'd0);
      checkOutput("s1_rel_src", {30'd0, active_src}, 32'd0);
      cycles(2);
      checkOutput("s1_count", en_count, 32'd1);
      checkOutput("s1_mask", en_mask, 32'h0000_0002);

      // Scenario 2: held for 30 cycles, steps at +1, +9, +13, +17, +21, +25, +29
      $display("[TB] scenario 2: auto-repeat timing");
      clearCounters();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
      cycles(30);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd10);
      cycles(10);
      checkOutput("s2_count", en_count, 32'd7);
      checkOutput("s2_mask", en_mask, 32'h2222_2202);
      checkOutput("s2_down", down_count, 32'd0);
      checkOutput("s2_busy", {31'd0, busy}, 32'd0);

      // Scenario 3: simultaneous up/down, up wins; clear then preempts
      $display("[TB] scenario 3: arbitration and clear preemption");
      clearCounters();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd10);
      cycles(1);
      checkOutput("s3_en", {31'd0, cnt_en}, 32'd1);
      checkOutput("s3_dir", {31'd0, cnt_dir}, 32'd1);
      checkOutput("s3_src", {30'd0, active_src}, 32'd1);
      cycles(10);
      checkOutput("s3_count", en_count, 32'd2);
      checkOutput("s3_down", down_count, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd10);
      cycles(1);
      checkOutput("s3_clr", {31'd0, cnt_clr}, 32'd1);
      checkOutput("s3_clr_en", {31'd0, cnt_en}, 32'd0);
      checkOutput("s3_clr_src", {30'd0, active_src}, 32'd3);
      cycles(1);
      checkOutput("s3_clr_once", {31'd0, cnt_clr}, 32'd0);
      cycles(10);
      checkOutput("s3_no_more_en", en_count, 32'd2);
      checkOutput("s3_clr_count", clr_count, 32'd1);
      checkOutput("s3_release_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd10);
      cycles(3);
      checkOutput("s3_clr_held_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd10);
      cycles(1);
      checkOutput("s3_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("s3_idle_src", {30'd0, active_src}, 32'd0);

      // Scenario 4: saturation at both ends, plus one step just below the ceiling
      $display("[TB] scenario 4: saturation");
      clearCounters();
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      cycles(1);
      checkOutput("s4_down_src", {30'd0, active_src}, 32'd2);
      checkOutput("s4_down_busy1", {31'd0, busy}, 32'd1);
      cycles(19);
      checkOutput("s4_down_busy20", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      cycles(1);
      checkOutput("s4_down_count", en_count, 32'd0);
      checkOutput("s4_down_idle", {31'd0, busy}, 32'd0);
      clearCounters();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd255);
      cycles(1);
      checkOutput("s4_up_src", {30'd0, active_src}, 32'd1);
      checkOutput("s4_up_busy1", {31'd0, busy}, 32'd1);
      cycles(19);
      checkOutput("s4_up_busy20", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd255);
      cycles(1);
      checkOutput("s4_up_count", en_count, 32'd0);
      clearCounters();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd254);
      cycles(1);
      checkOutput("s4_up254_en", {31'd0, cnt_en}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd254);
      cycles(2);

      // Scenario 5: down held through reset is ignored until released and pressed again
      $display("[TB] scenario 5: button held across reset");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd10);
      rst = 1'b1;
      cycles(2);
      checkOutput("s5_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      clearCounters();
      cycles(10);
      checkOutput("s5_held_count", en_count, 32'd0);
      checkOutput("s5_held_busy", {31'd0, busy}, 32'd1);
      checkOutput("s5_held_src", {30'd0, active_src}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd10);
      cycles(1);
      checkOutput("s5_idle_busy", {31'd0, busy}, 32'd0);
      clearCounters();
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd10);
      cycles(1);
      checkOutput("s5_en", {31'd0, cnt_en}, 32'd1);
      checkOutput("s5_dir", {31'd0, cnt_dir}, 32'd0);
      checkOutput("s5_src", {30'd0, active_src}, 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd10);
      cycles(3);
      checkOutput("s5_count", en_count, 32'd1);
      checkOutput("s5_down_count", down_count, 32'd1);

      // Scenario 6: asynchronous reset lands on a repeat step
      $display("[TB] scenario 6: reset during repeat");
      clearCounters();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
      cycles(13);
      checkOutput("s6_en_before", {31'd0, cnt_en}, 32'd1);
      checkOutput("s6_count_before", en_count, 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("s6_async_en", {31'd0, cnt_en}, 32'd0);
      checkOutput("s6_async_src", {30'd0, active_src}, 32'd0);
      checkOutput("s6_async_busy", {31'd0, busy}, 32'd1);
      cycles(3);
      rst = 1'b0;
      clearCounters();
      cycles(15);
      checkOutput("s6_held_count", en_count, 32'd0);
      checkOutput("s6_held_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd10);
      cycles(1);
      checkOutput("s6_idle_busy", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_cmd_controller.md
Name: counter_cmd_controller

Overview:
Sequencer between the debounced push-button levels and the 8-bit LED counter. It turns up, down and clear button activity into single-cycle counter commands. It arbitrates simultaneous presses by fixed priority and generates auto-repeat steps while a button is held. It sits after the debounce stages and drives the counter's enable, direction and clear inputs.

Parameters:
WIDTH, 8, counter width; also the width of cnt_value.
MAX_VALUE, 255, saturation ceiling for up steps; must be at most 2^WIDTH-1.
HOLD_CYCLES, 50_000_000, cycles of continuous hold after the first step before auto-repeat starts; must be at least 2.
REPEAT_CYCLES, 10_000_000, cycles between auto-repeat steps; must be at least 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_up  input  1  debounced, clk-synchronous level; 1 = pressed
btn_down  input  1  debounced, clk-synchronous level
btn_clr  input  1  debounced, clk-synchronous level
cnt_value  input  WIDTH  current counter value; used for saturation
cnt_en  output  1  one-cycle step pulse to the counter
cnt_dir  output  1  step direction: 1 = up, 0 = down; valid while cnt_en=1
cnt_clr  output  1  one-cycle synchronous clear pulse to the counter
busy  output  1  high in any state other than IDLE
active_src  output  2  current owner: 00 none, 01 up, 10 down, 11 clr

Behaviour:
- Registered copy btn_q of each button. Rising edge = btn & ~btn_q.
- All outputs are registered.
- Latency: a command pulse appears on the cycle after the edge or timer terminal count is sampled.
- Reset (async, rst=1): state=RELEASE, btn_q=000, timer=0, cnt_en=0, cnt_dir=0, cnt_clr=0, active_src=00, busy=1.
- Starting in RELEASE means a button held through reset is ignored until all buttons are released.
- Arbitration for simultaneous rising edges in the same cycle: clr > up > down. Losing edges are discarded, not queued.
- FSM states:
  - IDLE:
    - clr edge -> pulse cnt_clr, active_src=11, go RELEASE.
    - up or down edge -> latch owner and issue a step, timer=0, go ARMED.
  - ARMED:
    - Owner released -> IDLE, active_src=00.
    - Timer reaches HOLD_CYCLES-1 -> issue a step, timer=0, go REPEAT.
  - REPEAT:
    - Owner released -> IDLE.
    - Every REPEAT_CYCLES cycles (timer terminal count REPEAT_CYCLES-1) -> issue a step, timer=0.
  - RELEASE: stay until btn_up, btn_down and btn_clr are all 0, then go IDLE.
- A step is cnt_en=1 with cnt_dir = (owner==up) for one cycle.
- Saturation:
  - An up step is suppressed (cnt_en stays 0) when cnt_value >= MAX_VALUE.
  - A down step is suppressed when cnt_value == 0.
  - Suppression does not change the state or the timer.
- Preemption: a clr rising edge in ARMED or REPEAT pulses cnt_clr, sets active_src=11 and goes to RELEASE.
- Non-owner up/down activity in ARMED, REPEAT or RELEASE is ignored.
- Owner release and timer terminal count in the same cycle: release wins and no step is issued.
- cnt_en and cnt_clr are never high in the same cycle.
- Timer: width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). It saturates, never wraps, and is cleared on every state change.
- Reset asserted mid-hold or mid-repeat: outputs clear immediately (async). After rst deasserts the held button must be released before any new command.

Test Plan:
Use HOLD_CYCLES=8 and REPEAT_CYCLES=4 unless stated otherwise.
1. Reset released with all buttons low, then up pressed 3 cycles and released, cnt_value=5 -> exactly one cnt_en pulse with cnt_dir=1, one cycle after the press; busy returns to 0 after release.
2. Up held 30 cycles, cnt_value=10 -> first step at +1, next at +9, then at +13, +17, +21, +25, +29: 7 pulses total, none after release.
3. Up and down rise in the same cycle -> up steps only (cnt_dir=1), active_src=01. Then clr rises while up is held -> one cnt_clr pulse, no further cnt_en, state RELEASE until all buttons are low.
4. Saturation: down held with cnt_value=0 -> zero cnt_en pulses. Up held with cnt_value=255 -> zero pulses; busy=1 throughout the hold.
5. btn_down held high across reset deassertion -> no pulse until btn_down goes low and then rises again; that rise gives one pulse with cnt_dir=0.
6. rst asserted during REPEAT while cnt_en is high -> cnt_en and active_src go to 0 within the same cycle (async); no pulse while the button stays held afterwards.
